// File: rtl/mem_access_unit.sv
// Memory access stage between the CPU controller FSM and RAM: owns PC, data address and IR, runs req/ack to RAM.
// Latency: a RAM access takes 2 cycles minimum from cmd to busy=0, plus 1 per ack wait cycle; an MMIO access takes 1 cycle.
// Backpressure: combinational busy holds the controller; mem_req is held with stable addr/we/wdata until mem_ack.
//
// Optional feature macro: MEM_MMIO_EN (switch read at SW_ADDR, LED write at LED_ADDR, both served locally).
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   mem_cmd                    00 NONE, 01 WRITE, 10 READ, 11 illegal (treated as NONE, sets cmd_err)
//   addr_sel                   1: access at PC, 0: access at data address register
//   load_addr                  data address <= dp_out[ADDR_W-1:0]
//   load_pc, reset_pc          PC increment strobe; with reset_pc the PC clears instead
//   load_ir                    IR <= last completed read data
//   dp_out                     address source and write data
//   mem_rdata, mem_ack         RAM read data and one-cycle completion
//   sw                         board switches (MMIO only)
//   mem_req/we/addr/wdata      RAM request, registered at issue
//   mdata, ir, pc              last read data, instruction register, program counter
//   busy                       controller must stall
//   cmd_err                    sticky illegal command flag
//   led                        LED register (MMIO only, else 0)
module mem_access_unit #(
   parameter int               ADDR_W   = 9,
   parameter int               DATA_W   = 16,
   parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
   parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mem_cmd,
   input  logic              addr_sel,
   input  logic              load_addr,
   input  logic              load_pc,
   input  logic              reset_pc,
   input  logic              load_ir,
   input  logic [DATA_W-1:0] dp_out,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   input  logic [7:0]        sw,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mdata,
   output logic [DATA_W-1:0] ir,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              cmd_err,
   output logic [7:0]        led
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_READ  = 2'b10;
   localparam logic [1:0] CMD_ILL   = 2'b11;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   daddr_q, daddr_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                mem_we_q, mem_we_d;
   logic                cmd_err_q, cmd_err_d;
   logic [7:0]          led_q, led_d;
   logic [ADDR_W+1:0]   done_tag_q, done_tag_d;

   logic [1:0]          cmd_v;
   logic [ADDR_W-1:0]   cur_addr;
   logic                tag_match;
   logic                issue;
   logic                ack_take;
   logic                mmio_hit;

   // Illegal command behaves as NONE everywhere except the sticky error flag.
   assign cmd_v     = (mem_cmd == CMD_ILL) ? CMD_NONE : mem_cmd;
   assign cur_addr  = addr_sel ? pc_q : daddr_q;
   // A level-held command that matches the access just completed must not re-issue.
   assign tag_match = (state_q == ST_DONE) && ({cmd_v, cur_addr} == done_tag_q);
   assign issue     = (state_q == ST_IDLE) && (cmd_v != CMD_NONE);
   // Acks are only meaningful while a request is outstanding; stray or late acks are dropped.
   assign ack_take  = (state_q == ST_REQ) && mem_ack;

`ifdef MEM_MMIO_EN
   assign mmio_hit = ((cmd_v == CMD_READ)  && (cur_addr == SW_ADDR)) ||
                     ((cmd_v == CMD_WRITE) && (cur_addr == LED_ADDR));
`else
   assign mmio_hit = 1'b0;
   logic unused_mmio;
   assign unused_mmio = ^{sw, LED_ADDR, SW_ADDR};
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (issue) begin
               state_d = mmio_hit ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_ack) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if ((cmd_v == CMD_NONE) || !tag_match) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      mem_req = (state_q == ST_REQ);
      busy    = (cmd_v != CMD_NONE) && !tag_match;
   end

   // Datapath next-state
   always_comb begin
      pc_d        = pc_q;
      daddr_d     = daddr_q;
      ir_d        = ir_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = mem_we_q;
      cmd_err_d   = cmd_err_q;
      led_d       = led_q;
      done_tag_d  = done_tag_q;

      if (load_pc) begin
         pc_d = reset_pc ? '0 : pc_q + 1'b1;
      end
      if (load_addr) begin
         daddr_d = dp_out[ADDR_W-1:0];
      end
      if (load_ir) begin
         ir_d = rdata_q;
      end
      if (mem_cmd == CMD_ILL) begin
         cmd_err_d = 1'b1;
      end

      if (issue) begin
         mem_addr_d  = cur_addr;
         mem_wdata_d = dp_out;
         mem_we_d    = (cmd_v == CMD_WRITE);
`ifdef MEM_MMIO_EN
         if (mmio_hit) begin
            done_tag_d = {cmd_v, cur_addr};
            if (cmd_v == CMD_READ) begin
               rdata_d = {{(DATA_W-8){1'b0}}, sw};
            end else begin
               led_d = dp_out[7:0];
            end
         end
`endif
      end

      // The completed command is rebuilt from the registered we bit, since mem_cmd may have moved on.
      if (ack_take) begin
         if (!mem_we_q) begin
            rdata_d = mem_rdata;
         end
         done_tag_d = {(mem_we_q ? CMD_WRITE : CMD_READ), mem_addr_q};
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= '0;
         daddr_q     <= '0;
         ir_q        <= '0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         cmd_err_q   <= 1'b0;
         led_q       <= '0;
         done_tag_q  <= '0;
      end else begin
         pc_q        <= pc_d;
         daddr_q     <= daddr_d;
         ir_q        <= ir_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         cmd_err_q   <= cmd_err_d;
         led_q       <= led_d;
         done_tag_q  <= done_tag_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mdata     = rdata_q;
   assign ir        = ir_q;
   assign pc        = pc_q;
   assign cmd_err   = cmd_err_q;
   assign led       = led_q;

endmodule
